// File: rtl/stdp_spike_timer.sv
// stdp_spike_timer
// Measures the spacing between presynaptic and postsynaptic spike edges,
// offers a signed t_change to the weight-update datapath over valid/ready,
// then adds the returned weight_change to a weight register clamped to [0, W_MAX].
// Define STDP_TIMEOUT_EN to add a watchdog on the wait for dw_valid.
//
// state   | meaning
// IDLE    | no transaction in flight; spike-pair events are accepted
// SEND    | t_change offered (t_valid=1), waiting for t_ready
// WAIT_DW | waiting for dw_valid carrying weight_change
// APPLY   | captured weight_change is added to weight with clamping
module stdp_spike_timer #(
    parameter int N = 32,
    parameter int Q = 16,
    parameter int CNT_W = 16,
    parameter int TICK_SHIFT = 4,
    parameter logic [N-1:0] W_INIT = 32'h0000_8000,
    parameter logic [N-1:0] W_MAX = 32'h0001_0000,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pre_spike,
    input  logic         post_spike,
    output logic [N-1:0] t_change,
    output logic         t_valid,
    input  logic         t_ready,
    input  logic [N-1:0] weight_change,
    input  logic         dw_valid,
    output logic [N-1:0] weight,
    output logic         busy,
    output logic         drop,
    output logic         timeout_err
);

    localparam int SH = Q - TICK_SHIFT;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DW, APPLY} state_t;

    state_t           state_q, state_d;
    logic             pre_q, post_q;
    logic             pre_seen_q, post_seen_q;
    logic [CNT_W-1:0] pre_cnt_q, post_cnt_q;
    logic [CNT_W-1:0] pre_elapsed, post_elapsed;
    logic [N-1:0]     t_change_q, t_change_d;
    logic [N-1:0]     weight_q, weight_d;
    logic [N-1:0]     dw_q, dw_d;
    logic             drop_q;
    logic             pre_edge, post_edge;
    logic             ev_pot, ev_dep, ev_both, ev_any;
    logic [N-1:0]     ev_value;
    logic [N:0]       w_sum, dw_mag;

`ifdef STDP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             terr_q, terr_set;
`endif

    // Counter value scaled to Q-format time units; saturates to all ones.
    function automatic logic [N-2:0] cnt_to_mag(input logic [CNT_W-1:0] c);
        logic [CNT_W+N-1:0] wide;
        wide = {{N{1'b0}}, c} << SH;
        if (|wide[CNT_W+N-1:N-1]) return '1;
        return wide[N-2:0];
    endfunction

    assign pre_edge  = pre_spike & ~pre_q;
    assign post_edge = post_spike & ~post_q;

    // The counter loads 0 on the spike clock, so on a later clock the cycles
    // elapsed since that spike is the counter value plus one.
    assign pre_elapsed  = (pre_cnt_q == CNT_MAX) ? CNT_MAX : pre_cnt_q + 1'b1;
    assign post_elapsed = (post_cnt_q == CNT_MAX) ? CNT_MAX : post_cnt_q + 1'b1;

    assign ev_pot  = post_edge & pre_seen_q;
    assign ev_dep  = pre_edge & post_seen_q;
    assign ev_both = pre_edge & post_edge & (pre_seen_q | post_seen_q);
    assign ev_any  = ev_pot | ev_dep;
    assign ev_value = ev_both ? '0 :
                      ev_pot  ? {1'b0, cnt_to_mag(pre_elapsed)} :
                                {1'b1, cnt_to_mag(post_elapsed)};

    // Sign-magnitude add of the captured delta onto the non-negative weight.
    always_comb begin
        dw_mag = {2'b00, dw_q[N-2:0]};
        w_sum  = '0;
        if (!dw_q[N-1]) begin
            w_sum = {1'b0, weight_q} + dw_mag;
            if (w_sum > {1'b0, W_MAX}) w_sum = {1'b0, W_MAX};
        end else if (dw_mag <= {1'b0, weight_q}) begin
            w_sum = {1'b0, weight_q} - dw_mag;
        end
    end

    // Edge-detect registers, saturating counters and seen flags run in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q       <= 1'b0;
            post_q      <= 1'b0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            pre_seen_q  <= 1'b0;
            post_seen_q <= 1'b0;
        end else begin
            pre_q  <= pre_spike;
            post_q <= post_spike;
            if (pre_edge) pre_cnt_q <= '0;
            else if (pre_cnt_q != CNT_MAX) pre_cnt_q <= pre_cnt_q + 1'b1;
            if (post_edge) post_cnt_q <= '0;
            else if (post_cnt_q != CNT_MAX) post_cnt_q <= post_cnt_q + 1'b1;
            if (pre_edge) pre_seen_q <= 1'b1;
            if (post_edge) post_seen_q <= 1'b1;
        end
    end

    // Next-state and datapath-load decisions.
    always_comb begin
        state_d    = state_q;
        t_change_d = t_change_q;
        weight_d   = weight_q;
        dw_d       = dw_q;
`ifdef STDP_TIMEOUT_EN
        tmo_d      = tmo_q;
        terr_set   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ev_any) begin
                    t_change_d = ev_value;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (t_ready) begin
                    state_d = WAIT_DW;
`ifdef STDP_TIMEOUT_EN
                    tmo_d   = TMO_W'(TIMEOUT - 1);
`endif
                end
            end
            WAIT_DW: begin
                if (dw_valid) begin
                    dw_d    = weight_change;
                    state_d = APPLY;
                end
`ifdef STDP_TIMEOUT_EN
                else if (tmo_q == '0) begin
                    state_d  = IDLE;
                    terr_set = 1'b1;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
`endif
            end
            APPLY: begin
                weight_d = w_sum[N-1:0];
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            t_change_q <= '0;
            weight_q   <= W_INIT;
            dw_q       <= '0;
        end else begin
            state_q    <= state_d;
            t_change_q <= t_change_d;
            weight_q   <= weight_d;
            dw_q       <= dw_d;
        end
    end

    // Sticky flag for events that arrive while a transaction is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_q <= 1'b0;
        else if (ev_any && state_q != IDLE) drop_q <= 1'b1;
    end

`ifdef STDP_TIMEOUT_EN
    // Watchdog down-counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            if (terr_set) terr_q <= 1'b1;
        end
    end
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign t_change = t_change_q;
    assign t_valid  = (state_q == SEND);
    assign weight   = weight_q;
    assign busy     = (state_q != IDLE);
    assign drop     = drop_q;

endmodule

// File: tb/tb_stdp_spike_timer.sv
// Bench for stdp_spike_timer: a cycle model built from spike timestamps and a
// transaction phase is checked against the DUT after every clock, plus
// hand-computed expectations for the directed scenarios.
module tb_stdp_spike_timer;

    localparam logic [31:0] W_INIT  = 32'h0000_8000;
    localparam logic [31:0] W_MAX   = 32'h0001_0000;
    localparam int          TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pre_spike = 1'b0, post_spike = 1'b0;
    logic        t_ready = 1'b1, dw_valid = 1'b0;
    logic [31:0] weight_change = '0;
    logic [31:0] t_change, weight;
    logic        t_valid, busy, drop, timeout_err;

    int total = 0;
    int bad = 0;

    stdp_spike_timer dut (
        .clk(clk), .reset(reset), .pre_spike(pre_spike), .post_spike(post_spike),
        .t_change(t_change), .t_valid(t_valid), .t_ready(t_ready),
        .weight_change(weight_change), .dw_valid(dw_valid), .weight(weight),
        .busy(busy), .drop(drop), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase: 0 idle, 1 offering t_change, 2 awaiting delta, 3 applying delta.
    int          m_cyc, m_last_pre, m_last_post, m_phase, m_wait;
    bit          m_pre_seen, m_post_seen, m_pre_prev, m_post_prev;
    bit          m_drop, m_terr, m_live = 1'b0;
    logic [31:0] m_tch, m_weight, m_dw;
    int          hs_count = 0;

    function automatic logic [31:0] time_mag(input int cycles);
        longint m;
        m = (cycles > 65535) ? 65535 : cycles;
        m = m * 4096;
        if (m > 64'h7FFF_FFFF) m = 64'h7FFF_FFFF;
        return 32'(m);
    endfunction

    function automatic logic [31:0] apply_dw(input logic [31:0] w, input logic [31:0] d);
        longint r;
        r = longint'(w);
        if (d[31]) r = r - longint'(d[30:0]);
        else r = r + longint'(d[30:0]);
        if (r < 0) r = 0;
        if (r > longint'(W_MAX)) r = longint'(W_MAX);
        return 32'(r);
    endfunction

    always @(posedge clk or posedge reset) begin : model
        bit          pe, po, ev;
        logic [31:0] val;
        int          ph, wt;
        logic [31:0] tch, wgt, dw;
        bit          terr;
        if (reset) begin
            m_live <= 1'b1; m_cyc <= 0; m_last_pre <= 0; m_last_post <= 0;
            m_phase <= 0; m_wait <= 0; m_pre_seen <= 0; m_post_seen <= 0;
            m_pre_prev <= 0; m_post_prev <= 0; m_drop <= 0; m_terr <= 0;
            m_tch <= '0; m_weight <= W_INIT; m_dw <= '0;
        end else begin
            pe = pre_spike && !m_pre_prev;
            po = post_spike && !m_post_prev;
            ev = 1'b0; val = '0;
            if (pe && po && (m_pre_seen || m_post_seen)) begin
                ev = 1'b1; val = '0;
            end else if (po && m_pre_seen) begin
                ev = 1'b1; val = time_mag(m_cyc - m_last_pre);
            end else if (pe && m_post_seen) begin
                ev = 1'b1; val = 32'h8000_0000 | time_mag(m_cyc - m_last_post);
            end
            ph = m_phase; wt = m_wait; tch = m_tch; wgt = m_weight; dw = m_dw; terr = m_terr;
            case (m_phase)
                0: if (ev) begin tch = val; ph = 1; end
                1: if (t_ready) begin ph = 2; wt = 0; end
                2: begin
                    if (dw_valid) begin dw = weight_change; ph = 3; end
`ifdef STDP_TIMEOUT_EN
                    else if (wt == TIMEOUT - 1) begin ph = 0; terr = 1'b1; end
                    else wt = wt + 1;
`endif
                end
                default: begin wgt = apply_dw(m_weight, m_dw); ph = 0; end
            endcase
            if (ev && m_phase != 0) m_drop <= 1'b1;
            m_phase <= ph; m_wait <= wt; m_tch <= tch; m_weight <= wgt; m_dw <= dw; m_terr <= terr;
            if (pe) begin m_last_pre <= m_cyc; m_pre_seen <= 1'b1; end
            if (po) begin m_last_post <= m_cyc; m_post_seen <= 1'b1; end
            m_pre_prev <= pre_spike;
            m_post_prev <= post_spike;
            m_cyc <= m_cyc + 1;
        end
    end

    always @(posedge clk) begin
        if (!reset && t_valid && t_ready) hs_count <= hs_count + 1;
    end

    // Compare every output against the model shortly after each clock.
    always @(posedge clk) begin
        #1;
        if (m_live) begin
            chk("t_valid", {31'b0, t_valid}, {31'b0, m_phase == 1});
            chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
            chk("t_change", t_change, m_tch);
            chk("weight", weight, m_weight);
            chk("drop", {31'b0, drop}, {31'b0, m_drop});
            chk("timeout_err", {31'b0, timeout_err}, {31'b0, m_terr});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic pulse_pre();
        pre_spike = 1'b1;
        tick(1);
        pre_spike = 1'b0;
    endtask

    task automatic pulse_post();
        post_spike = 1'b1;
        tick(1);
        post_spike = 1'b0;
    endtask

    task automatic send_dw(input logic [31:0] v);
        weight_change = v;
        dw_valid = 1'b1;
        tick(1);
        dw_valid = 1'b0;
        weight_change = '0;
    endtask

    int hs0;

    initial begin
        tick(3);
        reset = 1'b0;
        chk("reset weight", weight, 32'h0000_8000);
        chk("reset t_valid", {31'b0, t_valid}, 32'd0);
        chk("reset t_change", t_change, 32'd0);
        chk("reset drop", {31'b0, drop}, 32'd0);

        // Potentiation: pre edge, post edge 32 cycles later.
        pulse_pre();
        tick(31);
        pulse_post();
        chk("pot t_valid", {31'b0, t_valid}, 32'd1);
        chk("pot t_change", t_change, 32'h0002_0000);
        tick(3);
        send_dw(32'h0000_2000);
        tick(1);
        chk("pot weight", weight, 32'h0000_a000);

        // Depression: post edge, pre edge 8 cycles later.
        do_reset();
        pulse_post();
        tick(7);
        pulse_pre();
        chk("dep t_change", t_change, 32'h8000_8000);
        tick(2);
        send_dw(32'h8000_4000);
        tick(1);
        chk("dep weight", weight, 32'h0000_4000);

        // Simultaneous edges once both sides have fired.
        tick(2);
        pre_spike = 1'b1;
        post_spike = 1'b1;
        tick(1);
        pre_spike = 1'b0;
        post_spike = 1'b0;
        chk("both t_valid", {31'b0, t_valid}, 32'd1);
        chk("both t_change", t_change, 32'h0000_0000);
        tick(2);
        send_dw(32'h0000_0000);
        tick(1);
        chk("both weight", weight, 32'h0000_4000);

        // dw_valid while idle is ignored.
        send_dw(32'h0001_0000);
        tick(2);
        chk("idle dw ignored", weight, 32'h0000_4000);

        // Clamping at both ends.
        do_reset();
        pulse_pre();
        tick(3);
        pulse_post();
        chk("clamp t_change", t_change, 32'h0000_4000);
        tick(1);
        send_dw(32'h0001_0000);
        tick(1);
        chk("clamp high", weight, 32'h0001_0000);
        tick(2);
        pulse_pre();
        tick(2);
        send_dw(32'h8002_0000);
        tick(1);
        chk("clamp low", weight, 32'h0000_0000);

        // Back-pressure with an extra event during SEND.
        do_reset();
        t_ready = 1'b0;
        pulse_pre();
        tick(1);
        pulse_post();
        chk("bp t_change", t_change, 32'h0000_2000);
        tick(3);
        pulse_pre();
        tick(5);
        chk("bp held t_change", t_change, 32'h0000_2000);
        chk("bp t_valid", {31'b0, t_valid}, 32'd1);
        chk("bp drop", {31'b0, drop}, 32'd1);
        hs0 = hs_count;
        t_ready = 1'b1;
        tick(3);
        chk("bp one handshake", 32'(hs_count - hs0), 32'd1);
        send_dw(32'h0000_0000);
        tick(2);
        chk("bp idle", {31'b0, busy}, 32'd0);
        chk("bp drop sticky", {31'b0, drop}, 32'd1);

        // Missing dw_valid.
        pulse_post();
        tick(70);
`ifdef STDP_TIMEOUT_EN
        chk("tmo idle", {31'b0, busy}, 32'd0);
        chk("tmo flag", {31'b0, timeout_err}, 32'd1);
        chk("tmo weight", weight, 32'h0000_8000);
        do_reset();
        chk("tmo cleared", {31'b0, timeout_err}, 32'd0);
`else
        chk("no tmo busy", {31'b0, busy}, 32'd1);
        chk("no tmo flag", {31'b0, timeout_err}, 32'd0);
        send_dw(32'h8000_1000);
        tick(1);
        chk("late dw weight", weight, 32'h0000_7000);
`endif
        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
